// File: rtl/l1_cache_control.sv
// Control FSM for a 2-way, write-back, write-allocate L1 cache. It sequences the
// data/tag/valid/dirty/LRU arrays of the datapath and the physical-memory line port.
module l1_cache_control #(
   parameter int s_offset  = 5,
   parameter int s_index   = 3,
   parameter int s_mask    = 2**s_offset,
   parameter int cnt_width = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [s_mask-1:0]    mem_byte_enable,
   output logic                 mem_resp,
   input  logic [1:0]           hit,
   input  logic [1:0]           valid,
   input  logic [1:0]           dirty,
   input  logic                 lru,
   output logic                 pmem_read,
   output logic                 pmem_write,
   input  logic                 pmem_resp,
   output logic                 pmem_addr_sel,
   output logic                 way_sel,
   output logic                 data_in_sel,
   output logic [s_mask-1:0]    data_we0,
   output logic [s_mask-1:0]    data_we1,
   output logic [1:0]           tag_load,
   output logic [1:0]           valid_load,
   output logic [1:0]           dirty_load,
   output logic                 dirty_in,
   output logic                 lru_load,
   output logic                 lru_in,
   output logic [cnt_width-1:0] hit_count,
   output logic [cnt_width-1:0] miss_count,
   output logic [1:0]           state_dbg
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] ALLOCATE  = 2'd2;
   localparam logic [1:0] SETTLE    = 2'd3;

   localparam logic [cnt_width-1:0] CNT_MAX = {cnt_width{1'b1}};
   localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

   logic [1:0]           state_q, state_d;
   logic                 victim_q, victim_d;
   logic [cnt_width-1:0] hit_count_q, hit_count_d;
   logic [cnt_width-1:0] miss_count_q, miss_count_d;
   logic                 req;
   logic                 hit_way;

   // CPU side: mem_read/mem_write are held until the single-cycle mem_resp.
   // Memory side: pmem_read/pmem_write are held until the single-cycle pmem_resp.
   assign req       = mem_read | mem_write;
   assign hit_way   = ~hit[0];
   assign state_dbg = state_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   always_comb begin
      state_d       = state_q;
      victim_d      = victim_q;
      hit_count_d   = hit_count_q;
      miss_count_d  = miss_count_q;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      way_sel       = 1'b0;
      data_in_sel   = 1'b0;
      data_we0      = '0;
      data_we1      = '0;
      tag_load      = 2'b00;
      valid_load    = 2'b00;
      dirty_load    = 2'b00;
      dirty_in      = 1'b0;
      lru_load      = 1'b0;
      lru_in        = 1'b0;
      // Strobes are suppressed during reset so a late pmem_resp cannot write the arrays.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (req && (hit != 2'b00)) begin
                  mem_resp = 1'b1;
                  way_sel  = hit_way;
                  lru_load = 1'b1;
                  lru_in   = ~hit_way;
                  if (hit_count_q != CNT_MAX) hit_count_d = hit_count_q + CNT_ONE;
                  if (mem_write) begin
                     dirty_load[hit_way] = 1'b1;
                     dirty_in            = 1'b1;
                     if (hit_way) data_we1 = mem_byte_enable;
                     else         data_we0 = mem_byte_enable;
                  end
               end else if (req) begin
                  victim_d = lru;
                  if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_ONE;
                  state_d = (valid[lru] && dirty[lru]) ? WRITEBACK : ALLOCATE;
               end
            end
            WRITEBACK: begin
               pmem_write    = 1'b1;
               pmem_addr_sel = 1'b1;
               way_sel       = victim_q;
               if (pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
               pmem_read = 1'b1;
               if (pmem_resp) begin
                  data_in_sel          = 1'b1;
                  tag_load[victim_q]   = 1'b1;
                  valid_load[victim_q] = 1'b1;
                  dirty_load[victim_q] = 1'b1;
                  if (victim_q) data_we1 = '1;
                  else          data_we0 = '1;
                  state_d = SETTLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         victim_q     <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         victim_q     <= victim_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

endmodule
